lab1_imul_prod_accum: RTL and testbench

LAB1_IMUL_PROD_ACCUM -- requirements
Module: lab1_imul_prod_accum

---
 rtl/lab1_imul_prod_accum.sv | 96 +++++++++
 tb/tb_lab1_imul_prod_accum.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lab1_imul_prod_accum.sv
// Product accumulator: sums p_count products from the multiplier stream and
// emits each group sum on a valid/ready output stream.
module lab1_imul_prod_accum #(
    parameter int p_count = 4,
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [p_nbits-1:0] istream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [p_nbits-1:0] ostream_msg
);

    localparam int c_cw = $clog2(p_count + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(p_count - 1);

    // state | meaning
    // ACCUM | collecting products, count = products taken so far
    // DONE  | holding a completed sum until downstream takes it
    typedef enum logic [1:0] {
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t             r_state;
    logic [c_cw-1:0]    r_count;
    logic [p_nbits-1:0] r_sum;
    logic               w_in_fire;
    logic               w_out_fire;

    // In DONE the input is only ready when the held sum leaves the same cycle.
    always_comb begin
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_ACCUM: istream_rdy = 1'b1;
                ST_DONE: begin
                    istream_rdy = ostream_rdy;
                    ostream_val = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ostream_msg = reset ? '0 : r_sum;
    assign w_in_fire   = istream_val & istream_rdy;
    assign w_out_fire  = ostream_val & ostream_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ACCUM;
            r_count <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_in_fire) begin
                        r_sum <= (r_count == '0) ? istream_msg : r_sum + istream_msg;
                        if (r_count == c_last) begin
                            r_count <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_count <= r_count + c_cw'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (w_out_fire) begin
                        if (w_in_fire) begin
                            r_sum <= istream_msg;
                            if (p_count == 1) begin
                                r_count <= '0;
                                r_state <= ST_DONE;
                            end else begin
                                r_count <= c_cw'(1);
                                r_state <= ST_ACCUM;
                            end
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab1_imul_prod_accum.sv
// Bench for lab1_imul_prod_accum: three instances (p_count 4, 2, 1), a vector
// table, hand sequences for the handshake corners, and a randomized run.
module tb_lab1_imul_prod_accum;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        ival  [3];
    logic        irdy  [3];
    logic [31:0] imsg  [3];
    logic        oval  [3];
    logic        ordy  [3];
    logic [31:0] omsg  [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lab1_imul_prod_accum #(.p_count(4), .p_nbits(32)) u_dut4 (
        .clk(clk), .reset(rst[0]),
        .istream_val(ival[0]), .istream_rdy(irdy[0]), .istream_msg(imsg[0]),
        .ostream_val(oval[0]), .ostream_rdy(ordy[0]), .ostream_msg(omsg[0]));

    lab1_imul_prod_accum #(.p_count(2), .p_nbits(32)) u_dut2 (
        .clk(clk), .reset(rst[1]),
        .istream_val(ival[1]), .istream_rdy(irdy[1]), .istream_msg(imsg[1]),
        .ostream_val(oval[1]), .ostream_rdy(ordy[1]), .ostream_msg(omsg[1]));

    lab1_imul_prod_accum #(.p_count(1), .p_nbits(32)) u_dut1 (
        .clk(clk), .reset(rst[2]),
        .istream_val(ival[2]), .istream_rdy(irdy[2]), .istream_msg(imsg[2]),
        .ostream_val(oval[2]), .ostream_rdy(ordy[2]), .ostream_msg(omsg[2]));

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] m;
        logic        o;
        logic        e_irdy;
        logic        e_oval;
        logic        cm;
        logic [31:0] e_msg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic v, logic [31:0] m, logic o,
                                logic e_irdy, logic e_oval, logic cm, logic [31:0] e_msg);
        vec_t t;
        t.r = r; t.v = v; t.m = m; t.o = o;
        t.e_irdy = e_irdy; t.e_oval = e_oval; t.cm = cm; t.e_msg = e_msg;
        return t;
    endfunction

    // Inputs change at negedge; outputs are looked at 1 ns later, before the posedge.
    task automatic drive(input int d, input logic r, input logic v,
                         input logic [31:0] m, input logic o);
        @(negedge clk);
        rst[d] = r; ival[d] = v; imsg[d] = m; ordy[d] = o;
        #1;
    endtask

    task automatic chk(input int d, input string nm, input logic e_irdy,
                       input logic e_oval, input logic cm, input logic [31:0] e_msg);
        n_cmp++;
        if (irdy[d] !== e_irdy || oval[d] !== e_oval || (cm && omsg[d] !== e_msg)) begin
            n_err++;
            $display("FAIL %s: dut%0d got irdy=%b oval=%b msg=%h, want irdy=%b oval=%b msg=%h",
                     nm, d, irdy[d], oval[d], omsg[d], e_irdy, e_oval, e_msg);
        end
    endtask

    task automatic step(input int d, input string nm, input logic r, input logic v,
                        input logic [31:0] m, input logic o, input logic e_irdy,
                        input logic e_oval, input logic cm, input logic [31:0] e_msg);
        drive(d, r, v, m, o);
        chk(d, nm, e_irdy, e_oval, cm, e_msg);
    endtask

    initial begin
        logic [31:0] pend[$];
        longint      gsum;
        int          gcnt, acc, outs;
        logic        v, o, e_oval, e_irdy;
        logic [31:0] m;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; ival[i] = 1'b0; imsg[i] = '0; ordy[i] = 1'b0;
        end

        // p_count=4 table: reset, 3+5+7+9, wraparound group, back-pressure,
        // out-fire coinciding with the next group's first product.
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 1, 32'h0));
        vecs.push_back(mk(1, 1, 32'h1234,     1, 0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 1, 32'd3,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd5,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd7,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd9,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 1, 32'd24));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd1,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd2,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd0,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 1, 32'd2));
        vecs.push_back(mk(0, 1, 32'd55,       0, 0, 1, 1, 32'd2));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 1, 32'd2));
        vecs.push_back(mk(0, 0, 32'hDEAD,     1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd10,       1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd1,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd1,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd1,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd100,      1, 1, 1, 1, 32'd13));
        vecs.push_back(mk(0, 1, 32'd1,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd2,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'd3,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 1, 32'd106));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 0, 0, 32'h0));

        for (int i = 0; i < vecs.size(); i++)
            step(0, $sformatf("vec%0d", i), vecs[i].r, vecs[i].v, vecs[i].m, vecs[i].o,
                 vecs[i].e_irdy, vecs[i].e_oval, vecs[i].cm, vecs[i].e_msg);

        // p_count=2: 30 held under back-pressure, then released alongside 1.
        step(1, "p2_rst",  1, 0, 0,      1, 0, 0, 1, 0);
        step(1, "p2_in10", 0, 1, 32'd10, 1, 1, 0, 0, 0);
        step(1, "p2_in20", 0, 1, 32'd20, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, "p2_hold", 0, 1, 32'd1, 0, 0, 1, 1, 32'd30);
        step(1, "p2_fire30", 0, 1, 32'd1, 1, 1, 1, 1, 32'd30);
        step(1, "p2_in2",    0, 1, 32'd2, 1, 1, 0, 0, 0);
        step(1, "p2_out3",   0, 0, 32'd0, 1, 1, 1, 1, 32'd3);
        step(1, "p2_idle",   0, 0, 32'd0, 1, 1, 0, 0, 0);

        // p_count=1: every product is its own sum, back-to-back in DONE.
        step(2, "p1_rst",  1, 0, 0,     1, 0, 0, 1, 0);
        step(2, "p1_in6",  0, 1, 32'd6, 1, 1, 0, 0, 0);
        step(2, "p1_out6", 0, 1, 32'd7, 1, 1, 1, 1, 32'd6);
        step(2, "p1_out7", 0, 1, 32'd8, 1, 1, 1, 1, 32'd7);
        step(2, "p1_out8", 0, 0, 32'd0, 1, 1, 1, 1, 32'd8);
        step(2, "p1_idle", 0, 0, 32'd0, 1, 1, 0, 0, 0);

        // p_count=4: reset after two products discards the partial sum.
        step(0, "mid_a",   0, 1, 32'd50, 1, 1, 0, 0, 0);
        step(0, "mid_b",   0, 1, 32'd60, 1, 1, 0, 0, 0);
        step(0, "mid_rst", 1, 1, 32'd70, 1, 0, 0, 1, 32'd0);
        step(0, "mid_1a",  0, 1, 32'd1,  1, 1, 0, 0, 0);
        step(0, "mid_1b",  0, 1, 32'd1,  1, 1, 0, 0, 0);
        step(0, "mid_1c",  0, 1, 32'd1,  1, 1, 0, 0, 0);
        step(0, "mid_1d",  0, 1, 32'd1,  1, 1, 0, 0, 0);
        step(0, "mid_out", 0, 0, 32'd0,  1, 1, 1, 1, 32'd4);
        step(0, "mid_idle",0, 0, 32'd0,  1, 1, 0, 0, 0);

        // Random handshakes on p_count=4 against a group-sum queue model.
        step(0, "rand_rst", 1, 0, 0, 1, 0, 0, 1, 0);
        gsum = 0; gcnt = 0; acc = 0; outs = 0;
        for (int cyc = 0; cyc < 3000 && (acc < 100 || pend.size() > 0); cyc++) begin
            v = (acc < 100) && ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       m = 32'hFFFFFFFF;
                1:       m = $urandom_range(0, 15);
                default: m = $urandom;
            endcase
            drive(0, 0, v, m, o);
            e_oval = (pend.size() > 0);
            e_irdy = (pend.size() == 0) || o;
            chk(0, "rand", e_irdy, e_oval, e_oval, e_oval ? pend[0] : 32'h0);
            if (e_oval && o) begin
                void'(pend.pop_front());
                outs++;
            end
            if (v && e_irdy) begin
                gsum += longint'(m);
                gcnt++;
                acc++;
                if (gcnt == 4) begin
                    pend.push_back(32'(gsum % 64'h1_0000_0000));
                    gsum = 0;
                    gcnt = 0;
                end
            end
        end
        n_cmp++;
        if (acc != 100 || outs != 25) begin
            n_err++;
            $display("FAIL rand_done: products=%0d sums=%0d, want products=100 sums=25", acc, outs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
